// File: rtl/clk_phase_pkg.sv
// clk_phase_pkg
//   Shared types and constants for the phase-select block: select FSM state
//   codes, phase index constants and the quadrature validity rule used by the
//   monitor.
package clk_phase_pkg;

  typedef logic [1:0] phase_t;
  typedef logic [1:0] sel_state_t;

  // Select FSM states
  localparam sel_state_t ST_IDLE      = 2'd0;
  localparam sel_state_t ST_GATE      = 2'd1;
  localparam sel_state_t ST_WAIT_FALL = 2'd2;
  localparam sel_state_t ST_DONE      = 2'd3;

  // Phase indices: bit i of the phase bus carries phase index i
  localparam phase_t PH_0   = 2'd0;
  localparam phase_t PH_90  = 2'd1;
  localparam phase_t PH_180 = 2'd2;
  localparam phase_t PH_270 = 2'd3;

  // A phase sample is consistent when 180/270 are the complements of 0/90
  // and 90 equals the previous cycle's 0 (90 lags 0 by one clk).
  function automatic logic quad_ok(input logic [3:0] cur, input logic [3:0] prev);
    return (cur[PH_180] == ~cur[PH_0]) &&
           (cur[PH_270] == ~cur[PH_90]) &&
           (cur[PH_90]  == prev[PH_0]);
  endfunction

endpackage

// File: rtl/clk_phase_select_monitor.sv
// clk_phase_monitor
//   Registers the four generator phases twice, checks the quadrature
//   relationship every cycle once both stages hold real samples, and keeps a
//   saturating run counter that drives lock plus a saturating error counter.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   ph_in       {clk_270, clk_180, clk_90, clk_0}
//   ph_q        ph_in delayed one clk
//   ph_qq       ph_in delayed two clk
//   locked      run counter has reached LOCK_CNT
//   phase_err   one-cycle pulse per invalid cycle
//   err_cnt     saturating count of invalid cycles
module clk_phase_monitor
  import clk_phase_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ph_in,
  output logic [3:0]       ph_q,
  output logic [3:0]       ph_qq,
  output logic             locked,
  output logic             phase_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(LOCK_CNT - 1);

  logic [1:0]       fill;
  logic [CNT_W-1:0] run_cnt;
  logic             checking;
  logic             cycle_ok;

  // fill counts the two pipeline loads after reset; checking starts once
  // ph_qq holds a real sample.
  assign checking = fill[1];
  assign cycle_ok = quad_ok(ph_q, ph_qq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q      <= '0;
      ph_qq     <= '0;
      fill      <= '0;
      run_cnt   <= '0;
      locked    <= 1'b0;
      phase_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      ph_q      <= ph_in;
      ph_qq     <= ph_q;
      phase_err <= 1'b0;
      if (!checking) begin
        fill <= fill + 2'd1;
      end else if (cycle_ok) begin
        if (run_cnt != CNT_MAX) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
        // lock follows the counter value after this update
        locked <= (run_cnt >= CNT_PRE);
      end else begin
        run_cnt   <= '0;
        locked    <= 1'b0;
        phase_err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clk_phase_select.sv
// clk_phase_select
//   Drives one of four quadrature divide-by-4 phases onto clk_out and switches
//   between them on a req/ack handshake without producing runt pulses. The
//   phase monitor supplies the delayed phase samples and lock status.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   ph_in       {clk_270, clk_180, clk_90, clk_0}
//   sel_req     phase change request (level, held until sel_ack)
//   sel_phase   requested phase index
//   sel_ack     one-cycle completion pulse
//   clk_out     selected phase, registered
//   cur_phase   phase index currently driving clk_out
//   locked      phase set has been valid for LOCK_CNT cycles
//   phase_err   one-cycle pulse per detected violation
//   err_cnt     saturating violation count
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | clk_out follows ph_q[cur_phase] while locked; accept requests
// GATE       | keep following current phase until it is low, then force 0
// WAIT_FALL  | clk_out held 0 until target phase shows a falling edge
// DONE       | pulse sel_ack, clk_out follows (new) cur_phase
module clk_phase_select
  import clk_phase_pkg::*;
#(
  parameter int          LOCK_CNT      = 8,
  parameter int          ERR_W         = 8,
  parameter int unsigned DEFAULT_PHASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ph_in,
  input  logic             sel_req,
  input  logic [1:0]       sel_phase,
  output logic             sel_ack,
  output logic             clk_out,
  output logic [1:0]       cur_phase,
  output logic             locked,
  output logic             phase_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam phase_t DEF_PH = phase_t'(DEFAULT_PHASE);

  logic [3:0] ph_q;
  logic [3:0] ph_qq;
  sel_state_t state;
  phase_t     target;
  logic       cur_bit;
  logic       tgt_now;
  logic       tgt_prev;
  logic       tgt_fall;

  clk_phase_monitor #(
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) u_monitor (
    .clk       (clk),
    .rst       (rst),
    .ph_in     (ph_in),
    .ph_q      (ph_q),
    .ph_qq     (ph_qq),
    .locked    (locked),
    .phase_err (phase_err),
    .err_cnt   (err_cnt)
  );

  assign cur_bit  = ph_q[cur_phase];
  assign tgt_now  = ph_q[target];
  assign tgt_prev = ph_qq[target];
  // Switching right after the target's falling edge means the new phase
  // still has one low cycle left, so the output low gap is at least 2 clk.
  assign tgt_fall = !tgt_now && tgt_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= DEF_PH;
      cur_phase <= DEF_PH;
      clk_out   <= 1'b0;
      sel_ack   <= 1'b0;
    end else begin
      sel_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_out <= cur_bit & locked;
          if (sel_req && locked) begin
            if (sel_phase == cur_phase) begin
              state <= ST_DONE;
            end else begin
              target <= sel_phase;
              state  <= ST_GATE;
            end
          end
        end
        ST_GATE: begin
          if (!locked) begin
            clk_out <= 1'b0;
            state   <= ST_IDLE;
          end else if (!cur_bit) begin
            // the current pulse has ended naturally; gate from here on
            clk_out <= 1'b0;
            state   <= ST_WAIT_FALL;
          end else begin
            clk_out <= 1'b1;
          end
        end
        ST_WAIT_FALL: begin
          clk_out <= 1'b0;
          if (!locked) begin
            state <= ST_IDLE;
          end else if (tgt_fall) begin
            cur_phase <= target;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          clk_out <= cur_bit & locked;
          sel_ack <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          clk_out <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
